psum_accumulator: RTL
=====================

# psum_accumulator

Downstream consumer of the PE cluster's output stream. It accumulates the per-channel partial-sum pulses (`o_peout_data` / `o_peout_valid`) across input channels into a local ofmap-row buffer. When the last channel completes, it drains the finished row to the output-feature-map writer over a valid/ready handshake, with optional ReLU. One instance per PE cluster.

## Interface
- `DATA_WIDTH`, 16: psum and ofmap word width, signed two's complement.
- `MAX_OFMAP_LEN`, 64: buffer depth, i.e. maximum psums per channel pass; `LOG_MOL = $clog2(MAX_OFMAP_LEN)`.
- `MAX_CHANNELS`, 64: maximum input channels per job; `LOG_MCH = $clog2(MAX_CHANNELS)`.

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `i_cfg_valid`  in  1  one-cycle job start pulse.
- `i_ofmap_len`  in  LOG_MOL+1  psums per channel pass, 1..MAX_OFMAP_LEN.
- `i_num_channels`  in  LOG_MCH+1  channels to accumulate, 1..MAX_CHANNELS.
- `i_relu_en`  in  1  clamp negative results to 0 on drain.
- `i_psum_data`  in  DATA_WIDTH  partial sum from the cluster.
- `i_psum_valid`  in  1  one-cycle pulse per psum; there is no back-pressure.
- `o_ofmap_data`  out  DATA_WIDTH  finished ofmap word.
- `o_ofmap_valid`  out  1  word available.
- `i_ofmap_ready`  in  1  downstream accepts the word.
- `o_busy`  out  1  high in ACCUM and DRAIN.
- `o_done`  out  1  one-cycle pulse after the last word is accepted.
- `o_err`  out  1  sticky error flag; cleared by the next accepted config.

## Operation
- FSM states are IDLE, ACCUM and DRAIN. Reset enters IDLE.
- IDLE:
  - `i_cfg_valid` with both lengths nonzero: latch the config, clear `wr_ptr`, `rd_ptr`, `ch_cnt` and `o_err`, then go to ACCUM.
  - `i_cfg_valid` with either length zero: stay in IDLE and set `o_err`.
- ACCUM, on each `i_psum_valid` (position `wr_ptr`):
  - When `ch_cnt == 0`: `buf[wr_ptr] <= i_psum_data` (overwrite, no add). Buffer contents are never reset.
  - Otherwise: `buf[wr_ptr] <= sat_add(buf[wr_ptr], i_psum_data)`.
  - `wr_ptr` increments. At `wr_ptr == ofmap_len-1` it wraps to 0 and `ch_cnt` increments.
  - When this wrap happens on channel `num_channels-1`, go to DRAIN.
- `sat_add` arithmetic:
  - Signed addition with a DATA_WIDTH+1 internal result.
  - Positive overflow saturates to `0x7FFF` and negative overflow to `0x8000` (DATA_WIDTH=16 values).
  - There is no wrap-around.
- DRAIN:
  - `o_ofmap_valid = 1`.
  - `o_ofmap_data = buf[rd_ptr]`, or 0 when `i_relu_en` is set and the word is negative.
  - On `o_ofmap_valid && i_ofmap_ready`, `rd_ptr` increments.
  - On acceptance of word `ofmap_len-1`: go to IDLE and pulse `o_done` in the following cycle.
  - Data and valid stay stable while ready is low.
- Error and ignore cases:
  - `i_psum_valid` in IDLE or DRAIN is dropped and sets `o_err`.
  - `i_psum_valid` in the same cycle as an accepted config is dropped and sets `o_err`, which overrides the clear.
  - `i_cfg_valid` in ACCUM or DRAIN is ignored and does not set `o_err`.

## Timing
- Reset values: all outputs 0, state IDLE, all pointers and counters 0.
- Psum update: written into `buf` at the clock edge of the valid pulse. A psum arriving the next cycle at a different address sees no hazard.
  - A same-address back-to-back hit can only occur when `ofmap_len == 1`. It must still accumulate correctly, which requires a read-after-write forward of the new value.
- The ACCUM-to-DRAIN transition happens on the edge of the final psum. `o_ofmap_valid` is high in the next cycle.
- Drain throughput is 1 word/cycle while ready is high. `o_ofmap_data` is combinational from the buffer registers and `rd_ptr`.
- `o_done` is asserted exactly one cycle after the final handshake, with `o_busy` already low.
- A new config is accepted in the same cycle `o_done` is high.
- Reset asserted mid-job aborts asynchronously: state IDLE, outputs 0. No partial result is emitted.

## Structure
- Shared package `slac_pkg`:
  - `acc_state_t` enum (IDLE, ACCUM, DRAIN).
  - Function `sat_add(a, b)`, parameterised on DATA_WIDTH via a localparam in the caller.
  - ReLU helper.
- One sub-module, `psum_buffer`:
  - Register array of MAX_OFMAP_LEN × DATA_WIDTH.
  - One write port and one combinational read port (rd_ptr), plus an accumulate read at wr_ptr.
  - No reset on the data array.

## Test plan
- Len=4, ch=1, psums 1,2,3,4, ready=1 → outputs 1,2,3,4 on consecutive cycles; `o_done` one cycle after the last; `o_err=0`.
- Len=3, ch=3, psums (10,20,30)×3 → outputs 30,60,90.
- Saturation, len=1, ch=2: 0x7000+0x2000 → 0x7FFF; 0x9000+0x9000 → 0x8000. The second case also checks the back-to-back same-address accumulate.
- ReLU on, len=2, ch=1, psums −5,7 → outputs 0,7. Ready toggled 1,0,0,1 → data held stable while stalled; exactly 2 handshakes.
- Error cases:
  - psum in IDLE → `o_err=1` and buffer unchanged.
  - cfg with len=0 → `o_err=1`, state stays IDLE.
  - next valid cfg → `o_err=0`.
- Reset asserted after 2 of 4 psums → all outputs 0 immediately. A subsequent job len=2, ch=1 with psums 5,6 → outputs 5,6, with no stale data.

Source files
------------

// File: rtl/slac_pkg.sv
// ============================================================================
// Module  : slac_pkg
// Brief   : Shared types and arithmetic helpers for the psum accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package slac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_t;

  // Saturating signed add for operands sign-extended from a w-bit word (w <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    s     = 33'(a) + 33'(b);
    max_v = (33'sd1 <<< (w - 1)) - 33'sd1;
    min_v = -(33'sd1 <<< (w - 1));
    if (s > max_v)      return 32'(max_v);
    else if (s < min_v) return 32'(min_v);
    else                return 32'(s);
  endfunction

  function automatic logic relu_zero(input logic sign_bit, input logic relu_en);
    return sign_bit & relu_en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/psum_buffer.sv
// ============================================================================
// Module  : psum_buffer
// Brief   : Flop-array ofmap-row buffer: one write port, accumulate and drain reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_buffer
  import slac_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 64,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_acc_addr,
  output logic [DATA_WIDTH-1:0] o_acc_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // A write is visible to the very next read, so a same-address back-to-back
  // accumulate (ofmap_len == 1) picks up the freshly written value.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_acc_data = r_mem[i_acc_addr];
  assign o_rd_data  = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/psum_accumulator.sv
// ============================================================================
// Module  : psum_accumulator
// Brief   : Accumulates per-channel psums into a row buffer, then drains it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_accumulator
  import slac_pkg::*;
#(
  parameter  int DATA_WIDTH    = 16,
  parameter  int MAX_OFMAP_LEN = 64,
  parameter  int MAX_CHANNELS  = 64,
  localparam int LOG_MOL       = $clog2(MAX_OFMAP_LEN),
  localparam int LOG_MCH       = $clog2(MAX_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cfg_valid,
  input  logic [LOG_MOL:0]      i_ofmap_len,
  input  logic [LOG_MCH:0]      i_num_channels,
  input  logic                  i_relu_en,
  input  logic [DATA_WIDTH-1:0] i_psum_data,
  input  logic                  i_psum_valid,
  output logic [DATA_WIDTH-1:0] o_ofmap_data,
  output logic                  o_ofmap_valid,
  input  logic                  i_ofmap_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  acc_state_t r_state, w_next_state;

  logic [LOG_MOL:0]       r_len;
  logic [LOG_MCH:0]       r_nch;
  logic                   r_relu;
  logic [LOG_MOL-1:0]     r_wr_ptr;
  logic [LOG_MOL-1:0]     r_rd_ptr;
  logic [LOG_MCH-1:0]     r_ch_cnt;
  logic                   r_done;
  logic                   r_err;

  logic                   w_cfg_ok;
  logic                   w_cfg_take;
  logic                   w_psum_take;
  logic                   w_last_pos;
  logic                   w_last_ch;
  logic                   w_hs;
  logic                   w_last_rd;
  logic [DATA_WIDTH-1:0]  w_acc_data;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  logic [DATA_WIDTH-1:0]  w_wr_data;
  logic signed [DATA_WIDTH-1:0] w_acc_s;
  logic signed [DATA_WIDTH-1:0] w_psum_s;

  assign w_cfg_ok    = i_cfg_valid && (i_ofmap_len != '0) && (i_num_channels != '0);
  assign w_cfg_take  = (r_state == IDLE) && w_cfg_ok;
  assign w_psum_take = (r_state == ACCUM) && i_psum_valid;
  assign w_last_pos  = ({1'b0, r_wr_ptr} == r_len - 1'b1);
  assign w_last_ch   = ({1'b0, r_ch_cnt} == r_nch - 1'b1);
  assign w_hs        = (r_state == DRAIN) && i_ofmap_ready;
  assign w_last_rd   = ({1'b0, r_rd_ptr} == r_len - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_cfg_take) w_next_state = ACCUM;
      ACCUM:   if (w_psum_take && w_last_pos && w_last_ch) w_next_state = DRAIN;
      DRAIN:   if (w_hs && w_last_rd) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len    <= '0;
      r_nch    <= '0;
      r_relu   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ch_cnt <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_hs && w_last_rd;

      if (w_cfg_take) begin
        r_len    <= i_ofmap_len;
        r_nch    <= i_num_channels;
        r_relu   <= i_relu_en;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_ch_cnt <= '0;
      end

      if (w_psum_take) begin
        if (w_last_pos) begin
          r_wr_ptr <= '0;
          r_ch_cnt <= r_ch_cnt + 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end

      if (w_hs) r_rd_ptr <= r_rd_ptr + 1'b1;

      // A dropped psum wins over the clear of an accepted config.
      if (i_psum_valid && (r_state != ACCUM))
        r_err <= 1'b1;
      else if (w_cfg_take)
        r_err <= 1'b0;
      else if ((r_state == IDLE) && i_cfg_valid)
        r_err <= 1'b1;
    end
  end

  assign w_acc_s   = w_acc_data;
  assign w_psum_s  = i_psum_data;
  assign w_wr_data = (r_ch_cnt == '0) ? i_psum_data
                   : DATA_WIDTH'(sat_add(32'(w_acc_s), 32'(w_psum_s), DATA_WIDTH));

  psum_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_OFMAP_LEN)
  ) u_buf (
    .clk        (clk),
    .i_we       (w_psum_take),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_data  (w_wr_data),
    .i_acc_addr (r_wr_ptr),
    .o_acc_data (w_acc_data),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_data  (w_rd_data)
  );

  assign o_ofmap_valid = (r_state == DRAIN);
  assign o_ofmap_data  = (o_ofmap_valid && !relu_zero(w_rd_data[DATA_WIDTH-1], r_relu))
                       ? w_rd_data : '0;
  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

`default_nettype wire
